// File: rtl/spi_reg_bank.sv
// SPI slave front-end with an addressable bank of analog control registers.
// Frames are validated and only committed to dout_p/dout_n on deselect.
module spi_reg_bank #(
    parameter int                DATA_W    = 8,
    parameter int                NUM_REGS  = 4,
    parameter int                ADDR_W    = 2,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sck,
    input  logic                         mosi,
    input  logic                         ss,
    output logic                         miso,
    output logic [NUM_REGS*DATA_W-1:0]   dout_p,
    output logic [NUM_REGS*DATA_W-1:0]   dout_n,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err
);

    localparam int CMD_W = 1 + ADDR_W;
    localparam int MAX_W = (CMD_W > DATA_W) ? CMD_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_DATA, S_DONE, S_ERR
    } state_t;

    logic [1:0] r_sck_s, r_ss_s, r_mosi_s, r_vld;
    logic       r_sck_d, r_ss_d, r_armed;

    // ss fall is only trusted once a genuine high level has been seen
    // after reset, so a frame cut by reset cannot restart by itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sck_s  <= '0;
            r_ss_s   <= '1;
            r_mosi_s <= '0;
            r_sck_d  <= 1'b0;
            r_ss_d   <= 1'b1;
            r_vld    <= '0;
            r_armed  <= 1'b0;
        end else begin
            r_sck_s  <= {r_sck_s[0], sck};
            r_ss_s   <= {r_ss_s[0], ss};
            r_mosi_s <= {r_mosi_s[0], mosi};
            r_sck_d  <= r_sck_s[1];
            r_ss_d   <= r_ss_s[1];
            r_vld    <= {r_vld[0], 1'b1};
            if (r_vld[1] && r_ss_s[1])
                r_armed <= 1'b1;
        end
    end

    logic w_sck_rise, w_sck_fall, w_ss_rise, w_ss_fall, w_mosi;

    assign w_sck_rise = r_sck_s[1] & ~r_sck_d;
    assign w_sck_fall = ~r_sck_s[1] & r_sck_d;
    assign w_ss_rise  = r_ss_s[1] & ~r_ss_d;
    assign w_ss_fall  = r_armed & r_ss_d & ~r_ss_s[1];
    assign w_mosi     = r_mosi_s[1];

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CMD_W-1:0]  r_cmd;
    logic [DATA_W-1:0] r_sh_in;
    logic [DATA_W-1:0] r_sh_out;
    logic              r_inv;
    logic              r_miso;
    logic              r_wr_strobe;
    logic              r_frame_err;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_regs [NUM_REGS];

    logic [CMD_W-1:0]  w_cmd_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              w_addr_ok;
    logic [DATA_W-1:0] w_rd;
    logic [DATA_W-1:0] w_sh_in_nxt;
    logic [DATA_W-1:0] w_sh_out_nxt;
    logic              w_commit_ok;

    assign w_cmd_nxt    = CMD_W'({r_cmd, w_mosi});
    assign w_addr_nxt   = w_cmd_nxt[ADDR_W-1:0];
    assign w_addr_ok    = int'(w_addr_nxt) < NUM_REGS;
    assign w_sh_in_nxt  = DATA_W'({r_sh_in, w_mosi});
    assign w_sh_out_nxt = r_sh_out << 1;
    assign w_commit_ok  = (r_state == S_DONE) && !r_inv;

    always_comb begin
        w_rd = '0;
        if (w_addr_ok)
            w_rd = r_regs[w_addr_nxt];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_cmd       <= '0;
            r_sh_in     <= '0;
            r_sh_out    <= '0;
            r_inv       <= 1'b0;
            r_miso      <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_frame_err <= 1'b0;
            r_wr_addr   <= '0;
            for (int k = 0; k < NUM_REGS; k++)
                r_regs[k] <= RESET_VAL;
        end else begin
            r_wr_strobe <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_ss_rise && r_state != S_IDLE) begin
                r_state <= S_IDLE;
                r_miso  <= 1'b0;
                if (w_commit_ok && r_cmd[ADDR_W]) begin
                    r_regs[r_cmd[ADDR_W-1:0]] <= r_sh_in;
                    r_wr_strobe <= 1'b1;
                    r_wr_addr   <= r_cmd[ADDR_W-1:0];
                end else if (!w_commit_ok) begin
                    r_frame_err <= 1'b1;
                end
            end else begin
                unique case (r_state)
                    S_IDLE: if (w_ss_fall) begin
                        r_state <= S_CMD;
                        r_cnt   <= '0;
                        r_cmd   <= '0;
                        r_inv   <= 1'b0;
                    end
                    S_CMD: if (w_sck_rise) begin
                        r_cmd <= w_cmd_nxt;
                        if (r_cnt == CNT_W'(CMD_W - 1)) begin
                            r_state  <= S_DATA;
                            r_cnt    <= '0;
                            r_sh_out <= w_rd;
                            r_miso   <= w_rd[DATA_W-1];
                            r_inv    <= !w_addr_ok;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    // the fall right after the command phase keeps the MSB
                    S_DATA: if (w_sck_rise) begin
                        r_sh_in <= w_sh_in_nxt;
                        if (r_cnt == CNT_W'(DATA_W - 1)) begin
                            r_state <= S_DONE;
                            r_miso  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else if (w_sck_fall && r_cnt != '0) begin
                        r_sh_out <= w_sh_out_nxt;
                        r_miso   <= w_sh_out_nxt[DATA_W-1];
                    end
                    S_DONE: if (w_sck_rise)
                        r_state <= S_ERR;
                    S_ERR: ;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
        assign dout_p[k*DATA_W +: DATA_W] = r_regs[k];
    end

    assign dout_n    = ~dout_p;
    assign miso      = r_miso;
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: 4-register and 3-register instances share the
// SPI pins and are checked against a frame-level model of the bank.
module tb_spi_reg_bank;

    logic        clk, rst, sck, mosi, ss;
    logic        miso0, miso1, ws0, ws1, fe0, fe1;
    logic [31:0] dp0, dn0;
    logic [23:0] dp1, dn1;
    logic [1:0]  wa0, wa1;

    spi_reg_bank u0 (
        .clk(clk), .rst(rst), .sck(sck), .mosi(mosi), .ss(ss),
        .miso(miso0), .dout_p(dp0), .dout_n(dn0),
        .wr_strobe(ws0), .wr_addr(wa0), .frame_err(fe0)
    );

    spi_reg_bank #(.NUM_REGS(3)) u1 (
        .clk(clk), .rst(rst), .sck(sck), .mosi(mosi), .ss(ss),
        .miso(miso1), .dout_p(dp1), .dout_n(dn1),
        .wr_strobe(ws1), .wr_addr(wa1), .frame_err(fe1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         n_vec = 0;
    int         n_err = 0;
    bit         in_win = 1'b0;
    bit         started = 1'b0;
    logic [7:0] m_reg [2][4];
    logic [1:0] m_wa [2];
    logic [7:0] cap [2];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic int nr(input int j);
        return (j == 0) ? 4 : 3;
    endfunction

    function automatic logic [31:0] msk(input int j);
        return (j == 0) ? 32'hFFFF_FFFF : 32'h00FF_FFFF;
    endfunction

    function automatic logic [31:0] mpack(input int j);
        logic [31:0] r = '0;
        for (int k = 0; k < nr(j); k++)
            r[k*8 +: 8] = m_reg[j][k];
        return r;
    endfunction

    function automatic logic [31:0] gdp(input int j);
        return (j == 0) ? dp0 : {8'h00, dp1};
    endfunction

    function automatic logic [31:0] gdn(input int j);
        return (j == 0) ? dn0 : {8'h00, dn1};
    endfunction

    function automatic logic gws(input int j);
        return (j == 0) ? ws0 : ws1;
    endfunction

    function automatic logic gfe(input int j);
        return (j == 0) ? fe0 : fe1;
    endfunction

    function automatic logic gmiso(input int j);
        return (j == 0) ? miso0 : miso1;
    endfunction

    function automatic logic [1:0] gwa(input int j);
        return (j == 0) ? wa0 : wa1;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 2; j++) begin
            m_wa[j] = 2'd0;
            for (int k = 0; k < 4; k++)
                m_reg[j][k] = 8'h00;
        end
    endtask

    // Between frame windows the outputs must sit still at the model state.
    always @(negedge clk) begin
        if (started && !in_win) begin
            for (int j = 0; j < 2; j++) begin
                chk($sformatf("dout_p%0d", j), gdp(j), mpack(j));
                chk($sformatf("dout_n%0d", j), gdn(j), ~mpack(j) & msk(j));
                chk($sformatf("strobe%0d", j), 32'(gws(j)), 32'd0);
                chk($sformatf("ferr%0d", j), 32'(gfe(j)), 32'd0);
                chk($sformatf("wr_addr%0d", j), 32'(gwa(j)), 32'(m_wa[j]));
                if (ss)
                    chk($sformatf("miso_idle%0d", j), 32'(gmiso(j)), 32'd0);
            end
        end
    end

    task automatic frame(input bit rw, input logic [1:0] a,
                         input logic [7:0] d, input int nrise,
                         input int rst_at);
        logic [10:0] f;
        bit          aborted, vld, full;
        bit          com [2];
        bit          er [2];
        int          sc [2], ec [2], sk [2], ek [2];
        logic [31:0] oldv [2], newv [2], ev;
        logic        eb;
        f = {rw, a, d};
        aborted = 1'b0;
        @(negedge clk);
        ss = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nrise; i++) begin
            mosi = (i < 11) ? f[10-i] : 1'($urandom);
            repeat (4) @(negedge clk);
            for (int j = 0; j < 2; j++) begin
                if (aborted) begin
                    chk($sformatf("miso_abort%0d", j), 32'(gmiso(j)), 32'd0);
                end else if (i >= 3 && i < 11) begin
                    vld = int'(a) < nr(j);
                    eb = vld ? m_reg[j][a][10-i] : 1'b0;
                    chk($sformatf("miso%0d_b%0d", j, 10 - i),
                        32'(gmiso(j)), 32'(eb));
                    cap[j][10-i] = gmiso(j);
                end
            end
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
            if (i == rst_at) begin
                in_win = 1'b1;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                model_reset();
                aborted = 1'b1;
                @(negedge clk);
                in_win = 1'b0;
            end
        end
        repeat (4) @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            vld = int'(a) < nr(j);
            full = (nrise == 11) && !aborted;
            com[j] = full && rw && vld;
            er[j] = !aborted && !(full && vld);
            oldv[j] = mpack(j);
            newv[j] = oldv[j];
            if (com[j])
                newv[j][a*8 +: 8] = d;
            sc[j] = 0; ec[j] = 0; sk[j] = 0; ek[j] = 0;
        end
        in_win = 1'b1;
        ss = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            for (int j = 0; j < 2; j++) begin
                if (gws(j)) begin sc[j]++; sk[j] = k; end
                if (gfe(j)) begin ec[j]++; ek[j] = k; end
                ev = (com[j] && sc[j] > 0) ? newv[j] : oldv[j];
                chk($sformatf("win_dp%0d_k%0d", j, k), gdp(j), ev);
                chk($sformatf("win_dn%0d_k%0d", j, k), gdn(j), ~ev & msk(j));
            end
        end
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("n_strobe%0d", j), 32'(sc[j]), 32'(com[j]));
            chk($sformatf("n_ferr%0d", j), 32'(ec[j]), 32'(er[j]));
            if (com[j])
                chk($sformatf("commit_lat%0d", j), 32'(sk[j] <= 4), 32'd1);
            if (er[j])
                chk($sformatf("ferr_lat%0d", j), 32'(ek[j] <= 4), 32'd1);
            if (com[j]) begin
                m_reg[j][a] = d;
                m_wa[j] = a;
            end
        end
        in_win = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int r, n;
        rst = 1'b1; ss = 1'b1; sck = 1'b0; mosi = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_dp0", dp0, 32'h0000_0000);
        chk("rst_dn0", dn0, 32'hFFFF_FFFF);
        chk("rst_dp1", {8'h00, dp1}, 32'h0000_0000);
        chk("rst_dn1", {8'h00, dn1}, 32'h00FF_FFFF);
        chk("rst_miso0", 32'(miso0), 32'd0);
        chk("rst_pulses", 32'({ws0, fe0, ws1, fe1}), 32'd0);
        started = 1'b1;

        frame(1'b1, 2'd2, 8'hA5, 11, -1);
        chk("wr_a5_dp0", dp0, 32'h00A5_0000);
        chk("wr_a5_dn0", dn0, 32'hFF5A_FFFF);
        chk("wr_a5_wa0", 32'(wa0), 32'd2);

        frame(1'b0, 2'd2, 8'($urandom), 11, -1);
        chk("rd_a5_miso0", 32'(cap[0]), 32'h0000_00A5);
        chk("rd_a5_model", mpack(0), 32'h00A5_0000);

        frame(1'b1, 2'd1, 8'h3C, 6, -1);
        chk("short_dp0", dp0, 32'h00A5_0000);
        frame(1'b1, 2'd1, 8'h3C, 11, -1);
        chk("wr_3c_dp0", dp0, 32'h00A5_3C00);

        frame(1'b1, 2'd0, 8'hFF, 12, -1);
        chk("overrun_dp0", dp0, 32'h00A5_3C00);

        frame(1'b1, 2'd3, 8'h77, 11, -1);
        chk("inv_dp1", {8'h00, dp1}, 32'h00A5_3C00);
        chk("wr3_dp0", dp0, 32'h77A5_3C00);
        frame(1'b0, 2'd3, 8'h00, 11, -1);
        chk("rd_inv_miso1", 32'(cap[1]), 32'h0000_0000);
        chk("rd3_miso0", 32'(cap[0]), 32'h0000_0077);

        frame(1'b1, 2'd0, 8'h11, 11, 4);
        chk("rst_mid_dp0", dp0, 32'h0000_0000);
        chk("rst_mid_dn0", dn0, 32'hFFFF_FFFF);

        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            if (r == 6) n = 12;
            else if (r == 7) n = $urandom_range(1, 10);
            else n = 11;
            frame(1'($urandom), 2'($urandom), 8'($urandom), n, -1);
        end

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
